// File: rtl/enc_serial_prio_pkg.sv
// enc_serial_prio_pkg: mode encodings and drain-state type shared by the serial encoder
package enc_serial_prio_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR = 1'b1;
    typedef enum logic {IDLE, DRAIN} state_e;
endpackage

// File: rtl/enc_serial_prio_prio_enc.sv
// prio_enc_rr: highest-set-bit search over a vector rotated so the search starts just below ptr
module prio_enc_rr #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    input  logic         rr,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [N-1:0] rot;
    logic [W-1:0] sh;
    assign sh = rr ? ptr : '0;
    // rot[N-1] is vec[ptr-1], rot[0] is vec[ptr]: the top of rot is searched first
    always_comb begin
        rot = '0;
        for (int j = 0; j < N; j++) rot[j] = vec[(int'(sh) + j) % N];
        any = |rot;
        idx = '0;
        for (int j = 0; j < N; j++) if (rot[j]) idx = W'((int'(sh) + j) % N);
    end
endmodule

// File: rtl/enc_serial_prio.sv
// enc_serial_prio: accepts a multi-hot vector and streams out the index of each set bit,
// in fixed-priority or round-robin order
module enc_serial_prio import enc_serial_prio_pkg::*; #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_vec,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         mode,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);
    logic [N-1:0] pend, pend_nxt;
    logic         mode_q, mode_nxt;
    logic [W-1:0] ptr, ptr_nxt, sel;
    logic         any;
    state_e       state;
    prio_enc_rr #(.N(N)) u_enc (
        .vec(pend),
        .ptr(ptr),
        .rr (mode_q == MODE_RR),
        .idx(sel),
        .any(any)
    );
    assign state = any ? DRAIN : IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend   <= '0;
            mode_q <= MODE_FIXED;
            ptr    <= '0;
        end else begin
            pend   <= pend_nxt;
            mode_q <= mode_nxt;
            ptr    <= ptr_nxt;
        end
    end
    // ptr follows every grant so a later round-robin vector resumes after it
    always_comb begin
        pend_nxt = pend;
        mode_nxt = mode_q;
        ptr_nxt  = ptr;
        if (req_valid && req_ready) begin
            pend_nxt = req_vec;
            mode_nxt = mode;
        end else if (out_valid && out_ready) begin
            pend_nxt = pend & ~(N'(1) << sel);
            ptr_nxt  = sel;
        end
    end
    always_comb begin
        req_ready = state == IDLE;
        out_valid = state == DRAIN;
        out_idx   = sel;
        out_last  = $onehot(pend);
    end
endmodule

// File: tb/tb_enc_serial_prio.sv
// tb_enc_serial_prio: directed and random checks of enc_serial_prio against a set-based reference model
module tb_enc_serial_prio;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_vec;
    logic       req_valid, mode, out_ready, req_ready, out_last, out_valid;
    logic [1:0] out_idx;
    logic [7:0] req_vec8;
    logic       req_valid8, mode8, out_ready8, req_ready8, out_last8, out_valid8;
    logic [2:0] out_idx8;
    int         n_checks = 0;
    int         n_fail = 0;
    bit   [3:0] m_pend;
    bit         m_mode;
    int         m_ptr;

    always #5 clk = ~clk;

    enc_serial_prio #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_vec(req_vec), .req_valid(req_valid), .req_ready(req_ready),
        .mode(mode), .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
    );
    enc_serial_prio #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_vec(req_vec8), .req_valid(req_valid8), .req_ready(req_ready8),
        .mode(mode8), .out_idx(out_idx8), .out_last(out_last8), .out_valid(out_valid8), .out_ready(out_ready8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // next index to emit: rr walks downward from ptr-1 wrapping to 3, ending at ptr itself
    function automatic int pick(input bit [3:0] p, input bit rr, input int ptr);
        if (rr) begin
            for (int s = 1; s <= 4; s++) if (p[(ptr - s + 4) % 4]) return (ptr - s + 4) % 4;
        end else begin
            for (int i = 3; i >= 0; i--) if (p[i]) return i;
        end
        return 0;
    endfunction

    task automatic step4(input bit rn, input bit v, input logic [3:0] vec, input bit md, input bit ordy, input int ei);
        int k;
        @(negedge clk);
        k = pick(m_pend, m_mode, m_ptr);
        chk("req_ready", req_ready, m_pend == 0);
        chk("out_valid", out_valid, m_pend != 0);
        chk("out_last", out_last, $countones(m_pend) == 1);
        if (m_pend != 0) chk("out_idx", out_idx, k);
        if (ei >= 0) chk("directed_idx", out_idx, ei);
        rst_n = rn;
        req_valid = v;
        req_vec = vec;
        mode = md;
        out_ready = ordy;
        if (!rn) begin
            m_pend = 0;
            m_mode = 0;
            m_ptr = 0;
        end else if (m_pend == 0) begin
            if (v) begin
                m_pend = vec;
                m_mode = md;
            end
        end else if (ordy) begin
            m_pend[k] = 1'b0;
            m_ptr = k;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_vec = '0; req_valid = 1'b0; mode = 1'b0; out_ready = 1'b1;
        req_vec8 = '0; req_valid8 = 1'b0; mode8 = 1'b0; out_ready8 = 1'b1;
        m_pend = '0; m_mode = 1'b0; m_ptr = 0;
        @(negedge clk);
        chk("rst_idx", out_idx, 0);
        chk("rst_ready8", req_ready8, 1);
        chk("rst_valid8", out_valid8, 0);
        // single-bit vectors, fixed priority
        step4(1, 1, 4'b1000, 0, 1, -1); step4(1, 0, 4'b0000, 0, 1, 3);
        step4(1, 1, 4'b0100, 0, 1, -1); step4(1, 0, 4'b0000, 0, 1, 2);
        step4(1, 1, 4'b0010, 0, 1, -1); step4(1, 0, 4'b0000, 0, 1, 1);
        step4(1, 1, 4'b0001, 0, 1, -1); step4(1, 0, 4'b0000, 0, 1, 0);
        // multi-hot fixed, with a vector offered during the drain
        step4(1, 1, 4'b1011, 0, 1, -1); step4(1, 1, 4'b0100, 0, 1, 3);
        step4(1, 1, 4'b0100, 0, 1, 1);  step4(1, 0, 4'b0000, 0, 1, 0);
        // round-robin pointer carries across vectors
        step4(0, 0, 4'b0000, 0, 1, -1);
        step4(1, 1, 4'b0110, 1, 1, -1); step4(1, 0, 4'b0000, 0, 1, 2); step4(1, 0, 4'b0000, 0, 1, 1);
        step4(1, 1, 4'b0101, 1, 1, -1); step4(1, 0, 4'b0000, 0, 1, 0); step4(1, 0, 4'b0000, 0, 1, 2);
        // stall holds output, ignored vector during drain
        step4(1, 1, 4'b1111, 0, 1, -1);
        step4(1, 1, 4'b0001, 1, 0, 3); step4(1, 1, 4'b0001, 1, 0, 3); step4(1, 1, 4'b0001, 1, 0, 3);
        step4(1, 0, 4'b0000, 0, 1, 3); step4(1, 0, 4'b0000, 0, 1, 2);
        step4(1, 0, 4'b0000, 0, 1, 1); step4(1, 0, 4'b0000, 0, 1, 0);
        // all-zero vector, then reset mid-drain
        step4(1, 1, 4'b0000, 0, 1, -1);
        step4(1, 1, 4'b1110, 1, 1, -1);
        step4(0, 0, 4'b0000, 0, 1, 3);
        step4(1, 1, 4'b0011, 1, 1, -1); step4(1, 0, 4'b0000, 0, 1, 1); step4(1, 0, 4'b0000, 0, 1, 0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step4($urandom_range(0, 39) != 0, 1'($urandom), 4'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0, -1);
        step4(1, 0, 4'b0000, 0, 0, -1);
        step4(0, 0, 4'b0000, 0, 1, -1);
        step4(1, 0, 4'b0000, 0, 1, -1);
        // N=8 round-robin wrap
        @(negedge clk);
        chk("n8_ready", req_ready8, 1);
        req_vec8 = 8'b1000_0001; mode8 = 1'b1; req_valid8 = 1'b1;
        @(negedge clk);
        req_valid8 = 1'b0;
        chk("n8_a0_idx", out_idx8, 7); chk("n8_a0_last", out_last8, 0); chk("n8_a0_valid", out_valid8, 1);
        @(negedge clk);
        chk("n8_a1_idx", out_idx8, 0); chk("n8_a1_last", out_last8, 1);
        @(negedge clk);
        chk("n8_bubble", req_ready8, 1);
        req_valid8 = 1'b1;
        @(negedge clk);
        req_valid8 = 1'b0;
        chk("n8_b0_idx", out_idx8, 7); chk("n8_b0_last", out_last8, 0);
        @(negedge clk);
        chk("n8_b1_idx", out_idx8, 0); chk("n8_b1_last", out_last8, 1);
        @(negedge clk);
        chk("n8_done", out_valid8, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
